// File: rtl/vga_sync_generator.sv
// VGA raster timing master for the pong display path.
// Scans the horizontal/vertical counters, presents them to the pixel source,
// and re-times the returned pixel together with sync/blank onto the DAC pins.
//
// Ports:
//   VGA_CLOCK   pixel clock, all logic on the rising edge
//   RESET       synchronous active-high reset
//   PIXEL       {R,G,B} from the pixel source, PIXEL_LATENCY clocks after PIXEL_H/PIXEL_V
//   PIXEL_H     horizontal count 0..H_TOTAL-1 (unclamped in blanking)
//   PIXEL_V     vertical count 0..V_TOTAL-1 (unclamped in blanking)
//   VGA_RGB     registered {R,G,B}, forced to 0 outside the visible area
//   VGA_HSYNC   registered horizontal sync
//   VGA_VSYNC   registered vertical sync
//   ACTIVE      registered, high while VGA_RGB carries a visible pixel
//   FRAME_DONE  one-clock strobe at the start of vertical blanking
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE     = 800,
  parameter int unsigned H_FRONT       = 56,
  parameter int unsigned H_SYNC        = 120,
  parameter int unsigned H_BACK        = 64,
  parameter int unsigned V_VISIBLE     = 600,
  parameter int unsigned V_FRONT       = 37,
  parameter int unsigned V_SYNC        = 6,
  parameter int unsigned V_BACK        = 23,
  parameter bit          HSYNC_ACTIVE  = 1'b1,
  parameter bit          VSYNC_ACTIVE  = 1'b1,
  parameter int unsigned PIXEL_LATENCY = 1
) (
  input  logic        VGA_CLOCK,
  input  logic        RESET,
  input  logic [2:0]  PIXEL,
  output logic [10:0] PIXEL_H,
  output logic [10:0] PIXEL_V,
  output logic [2:0]  VGA_RGB,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        ACTIVE,
  output logic        FRAME_DONE
);

  localparam int unsigned CNT_W    = 11;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;

  logic vis_c;
  logic hs_c;
  logic vs_c;

  // Bit [0] is the newest stage; the top bit lines up with PIXEL.
  logic [PIXEL_LATENCY-1:0] vis_sr;
  logic [PIXEL_LATENCY-1:0] hs_sr;
  logic [PIXEL_LATENCY-1:0] vs_sr;

  // Raster counters: h every clock, v on each h wrap.
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      h <= '0;
      v <= '0;
    end else if (h == CNT_W'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  assign PIXEL_H = h;
  assign PIXEL_V = v;

  // Stage-0 decode straight from the counters.
  always_comb begin
    vis_c = (h < CNT_W'(H_VISIBLE)) && (v < CNT_W'(V_VISIBLE));
    hs_c  = (h >= CNT_W'(HS_START)) && (h <= CNT_W'(HS_END));
    vs_c  = (v >= CNT_W'(VS_START)) && (v <= CNT_W'(VS_END));
  end

  // Delay decode by the pixel-source latency so it meets the returning PIXEL.
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      vis_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
    end else begin
      vis_sr <= (vis_sr << 1) | PIXEL_LATENCY'(vis_c);
      hs_sr  <= (hs_sr << 1)  | PIXEL_LATENCY'(hs_c);
      vs_sr  <= (vs_sr << 1)  | PIXEL_LATENCY'(vs_c);
    end
  end

  // Pin registers: RGB, sync and ACTIVE for one coordinate leave together.
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      VGA_RGB    <= 3'b000;
      VGA_HSYNC  <= ~HSYNC_ACTIVE;
      VGA_VSYNC  <= ~VSYNC_ACTIVE;
      ACTIVE     <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      VGA_RGB    <= vis_sr[PIXEL_LATENCY-1] ? PIXEL : 3'b000;
      VGA_HSYNC  <= hs_sr[PIXEL_LATENCY-1] ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      VGA_VSYNC  <= vs_sr[PIXEL_LATENCY-1] ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      ACTIVE     <= vis_sr[PIXEL_LATENCY-1];
      FRAME_DONE <= (h == '0) && (v == CNT_W'(V_VISIBLE));
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Self-checking bench for vga_sync_generator. Two instances with a shrunken
// raster (28x17 clocks/lines): A with latency 1 and active-high syncs, B with
// latency 3 and active-low syncs. Expected pins come from the raster position
// computed arithmetically from the number of clocks since the last reset.
module tb_vga_sync_generator;

  localparam int HV = 16, HF = 3, HSW = 5, HB = 4;
  localparam int VV = 10, VF = 2, VSW = 3, VB = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        RESET;
  logic [2:0]  pix_a, pix_b;
  logic [10:0] ph_a, pv_a, ph_b, pv_b;
  logic [2:0]  rgb_a, rgb_b;
  logic        hs_a, vs_a, act_a, fd_a;
  logic        hs_b, vs_b, act_b, fd_b;

  int checks = 0;
  int errors = 0;
  int s = 0;                 // clocks since last reset edge = raster position
  logic [2:0] last_pa, last_pb;

  vga_sync_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1), .PIXEL_LATENCY(1)
  ) dut_a (
    .VGA_CLOCK(clk), .RESET(RESET), .PIXEL(pix_a),
    .PIXEL_H(ph_a), .PIXEL_V(pv_a), .VGA_RGB(rgb_a),
    .VGA_HSYNC(hs_a), .VGA_VSYNC(vs_a), .ACTIVE(act_a), .FRAME_DONE(fd_a)
  );

  vga_sync_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .PIXEL_LATENCY(3)
  ) dut_b (
    .VGA_CLOCK(clk), .RESET(RESET), .PIXEL(pix_b),
    .PIXEL_H(ph_b), .PIXEL_V(pv_b), .VGA_RGB(rgb_b),
    .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b), .ACTIVE(act_b), .FRAME_DONE(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster model: position n clocks after reset.
  function automatic int h_of(input int n); return n % HT; endfunction
  function automatic int v_of(input int n); return (n / HT) % VT; endfunction
  function automatic bit is_vis(input int n);
    return (h_of(n) < HV) && (v_of(n) < VV);
  endfunction
  function automatic bit is_hs(input int n);
    return (h_of(n) >= HV + HF) && (h_of(n) < HV + HF + HSW);
  endfunction
  function automatic bit is_vs(input int n);
    return (v_of(n) >= VV + VF) && (v_of(n) < VV + VF + VSW);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (s=%0d)", tag, obs, exp, s);
    end
  endtask

  task automatic check_dut(input string nm, input int lat, input bit hact, input bit vact,
                           input logic [10:0] ph, input logic [10:0] pv,
                           input logic [2:0] rgb, input logic hs, input logic vs,
                           input logic act, input logic fd, input logic [2:0] lastp);
    bit e_vis, e_hs, e_vs, e_fd;
    int t;
    e_vis = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fd = 1'b0;
    if (s > 0) begin
      // Pins now show the coordinate held lat+1 clocks ago; earlier = flushed.
      t = s - 1 - lat;
      if (t >= 0) begin
        e_vis = is_vis(t);
        e_hs  = is_hs(t);
        e_vs  = is_vs(t);
      end
      e_fd = (h_of(s - 1) == 0) && (v_of(s - 1) == VV);
    end
    chk({nm, "_pixel_h"}, 32'(ph), 32'(h_of(s)));
    chk({nm, "_pixel_v"}, 32'(pv), 32'(v_of(s)));
    chk({nm, "_rgb"}, 32'(rgb), e_vis ? 32'(lastp) : 32'd0);
    chk({nm, "_active"}, 32'(act), 32'(e_vis));
    chk({nm, "_hsync"}, 32'(hs), e_hs ? 32'(hact) : 32'(!hact));
    chk({nm, "_vsync"}, 32'(vs), e_vs ? 32'(vact) : 32'(!vact));
    chk({nm, "_frame_done"}, 32'(fd), 32'(e_fd));
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge.
  task automatic cycle(input logic rst, input logic [2:0] pa, input logic [2:0] pb);
    RESET = rst;
    pix_a = pa;
    pix_b = pb;
    @(posedge clk);
    if (rst) s = 0; else s = s + 1;
    last_pa = pa;
    last_pb = pb;
    @(negedge clk);
    check_dut("A", 1, 1'b1, 1'b1, ph_a, pv_a, rgb_a, hs_a, vs_a, act_a, fd_a, last_pa);
    check_dut("B", 3, 1'b0, 1'b0, ph_b, pv_b, rgb_b, hs_b, vs_b, act_b, fd_b, last_pb);
  endtask

  initial begin
    int fd_cnt, hs_cnt_a, hs_cnt_b, vs_cnt_a, vs_cnt_b, act_cnt_a, act_cnt_b;
    int first_fd, prev_fd, rlen;
    logic [2:0] ra, rb;
    bit spacing_ok;

    RESET = 1'b1; pix_a = 3'b000; pix_b = 3'b000;
    last_pa = 3'b000; last_pb = 3'b000;

    // Power-on reset, held three clocks.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b000, 3'b000);

    // Three undisturbed frames with random pixels; accumulate pin statistics.
    fd_cnt = 0; hs_cnt_a = 0; hs_cnt_b = 0; vs_cnt_a = 0; vs_cnt_b = 0;
    act_cnt_a = 0; act_cnt_b = 0; first_fd = -1; prev_fd = -1; spacing_ok = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      ra = 3'($urandom); rb = 3'($urandom);
      cycle(1'b0, ra, rb);
      if (fd_a === 1'b1) begin
        fd_cnt++;
        if (first_fd < 0) first_fd = s;
        if (prev_fd >= 0 && s - prev_fd != FRAME) spacing_ok = 1'b0;
        prev_fd = s;
      end
      if (hs_a === 1'b1) hs_cnt_a++;
      if (hs_b === 1'b0) hs_cnt_b++;
      if (vs_a === 1'b1) vs_cnt_a++;
      if (vs_b === 1'b0) vs_cnt_b++;
      if (act_a === 1'b1) act_cnt_a++;
      if (act_b === 1'b1) act_cnt_b++;
    end
    chk("frame_done_count", 32'(fd_cnt), 32'd3);
    chk("frame_done_first", 32'(first_fd), 32'(VV * HT + 1));
    chk("frame_done_spacing", 32'(spacing_ok), 32'd1);
    chk("hsync_clocks_A", 32'(hs_cnt_a), 32'(3 * VT * HSW));
    chk("hsync_clocks_B", 32'(hs_cnt_b), 32'(3 * VT * HSW));
    chk("vsync_clocks_A", 32'(vs_cnt_a), 32'(3 * VSW * HT));
    chk("vsync_clocks_B", 32'(vs_cnt_b), 32'(3 * VSW * HT));
    chk("active_clocks_A", 32'(act_cnt_a), 32'(3 * VV * HV));
    chk("active_clocks_B", 32'(act_cnt_b), 32'(3 * VV * HV));

    // Constant pixel: RGB must be 101 exactly while ACTIVE, else 0.
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 3'b101, 3'b101);
      chk("blank_gate_A", 32'(rgb_a), act_a ? 32'd5 : 32'd0);
    end

    // Advance to mid-frame (h=12, v=5), then a three-clock reset.
    for (int i = 0; i < 2 * FRAME && !(h_of(s) == 12 && v_of(s) == 5); i++)
      cycle(1'b0, 3'($urandom), 3'($urandom));
    chk("reached_mid_frame", 32'(ph_a), 32'd12);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b111, 3'b111);
    chk("reset_h", 32'(ph_a), 32'd0);
    chk("reset_v", 32'(pv_b), 32'd0);
    for (int i = 0; i < 60; i++) cycle(1'b0, 3'b111, 3'b111);

    // Random pixels with occasional short resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rlen = int'($urandom_range(1, 3));
        for (int k = 0; k < rlen; k++) cycle(1'b1, 3'($urandom), 3'($urandom));
      end else begin
        cycle(1'b0, 3'($urandom), 3'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Display-side timing master for the pong pipeline, clocked by VGA_CLOCK (50 MHz, 800x600@72 Hz).
- Scans raster counters and presents them as PIXEL_H/PIXEL_V to the pixel source (game engine).
- Accepts the registered 3-bit PIXEL back, aligns sync/blank to the pixel-source latency, and drives the DAC-side RGB and sync pins.
- Also emits a once-per-frame strobe for game-state updates.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (clocks)
- H_SYNC, 120, horizontal sync width (clocks)
- H_BACK, 64, horizontal back porch (clocks); H_TOTAL = 1040
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines); V_TOTAL = 666
- HSYNC_ACTIVE, 1, asserted level of VGA_HSYNC
- VSYNC_ACTIVE, 1, asserted level of VGA_VSYNC
- PIXEL_LATENCY, 1, clocks from PIXEL_H/PIXEL_V to matching PIXEL; legal values 1..4

Ports:
- VGA_CLOCK  input  1  pixel clock; all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- PIXEL  input  3  {R,G,B} from pixel source, valid PIXEL_LATENCY clocks after coordinates
- PIXEL_H  output  11  current horizontal count 0..H_TOTAL-1
- PIXEL_V  output  11  current vertical count 0..V_TOTAL-1
- VGA_RGB  output  3  registered {R,G,B} to DAC
- VGA_HSYNC  output  1  registered horizontal sync
- VGA_VSYNC  output  1  registered vertical sync
- ACTIVE  output  1  registered; high when VGA_RGB carries a visible pixel
- FRAME_DONE  output  1  single-cycle strobe at start of vertical blanking

Behaviour:
- Reset is synchronous and active-high; single clock VGA_CLOCK.
- Reset values: h=0, v=0, VGA_RGB=0, VGA_HSYNC=!HSYNC_ACTIVE, VGA_VSYNC=!VSYNC_ACTIVE, ACTIVE=0, FRAME_DONE=0. All delay-line stages cleared to inactive/deasserted.
- Counters:
  - h increments every clock and wraps H_TOTAL-1 -> 0.
  - v increments only when h wraps, and wraps V_TOTAL-1 -> 0 at (h,v) = (H_TOTAL-1, V_TOTAL-1).
  - PIXEL_H/PIXEL_V are driven directly from the counter registers; values in blanking are not clamped.
- Stage-0 decode from counters:
  - vis = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hs = h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (856..975 default)
  - vs = v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (637..642 default)
- Alignment:
  - vis/hs/vs pass through a PIXEL_LATENCY-deep shift register.
  - On each clock, output registers load: VGA_RGB = vis_d ? PIXEL : 3'b000; ACTIVE = vis_d; VGA_HSYNC = hs_d ? HSYNC_ACTIVE : !HSYNC_ACTIVE; VGA_VSYNC likewise.
  - Total latency is counter value -> pins = PIXEL_LATENCY+1 clocks. RGB, sync and ACTIVE for one coordinate appear on the same cycle.
- Blanking: PIXEL is ignored whenever vis_d=0; VGA_RGB is forced to 0 regardless of PIXEL.
- FRAME_DONE: registered; high for exactly one clock, the cycle after counters equal (h=0, v=V_VISIBLE). Exactly one pulse per frame.
- Reset mid-frame: next clock after RESET=1 gives counters (0,0) and all outputs at reset values. The first visible pixel reaches VGA_RGB PIXEL_LATENCY+1 clocks after RESET deasserts.
- Widths: 11-bit counters hold up to 2047. Parameter sums must not exceed 2047; there is no run-time check.

Test Plan:
- Reset: hold RESET 3 clocks mid-line (h=400, v=300) -> next clock PIXEL_H=0, PIXEL_V=0; VGA_HSYNC=0, VGA_VSYNC=0, VGA_RGB=0, ACTIVE=0, FRAME_DONE=0; delay lines flushed (no stale RGB after release).
- Counter wrap: run from reset -> PIXEL_H goes 1039->0 while PIXEL_V goes 0->1; at (1039,665) next is (0,0); 1040*666 = 692640 clocks per frame.
- Sync timing, PIXEL_LATENCY=1: HSYNC pin high exactly 120 clocks per line, rising 2 clocks after PIXEL_H=856. VSYNC high for lines 637..642 (6*1040 clocks), rising 2 clocks after (h=0, v=637).
- Pixel alignment: bench model registers PIXEL=3'b111 when PIXEL_H in 700..750, else 000 -> VGA_RGB=111 exactly 51 clocks per visible line, first at 2 clocks after PIXEL_H=700, ACTIVE=1 on those cycles. Repeat with PIXEL_LATENCY=3 and a 3-stage model -> same 51-clock window shifted to 4 clocks.
- Blank gating: tie PIXEL=3'b101 constant -> VGA_RGB=101 only while ACTIVE=1; 0 for all 240 blank clocks of each line and all 66 blank lines.
- Frame strobe: over 3 frames -> FRAME_DONE pulses exactly 3 times, each one clock wide, the cycle after (PIXEL_H=0, PIXEL_V=600); spacing exactly 692640 clocks.
